// File: rtl/ibex_pkg.sv
// Shared LSU types: access size encoding and the response-unit sequencer states.
package ibex_pkg;

   typedef enum logic [1:0] {
      LSU_WORD = 2'b00,
      LSU_HALF = 2'b01,
      LSU_BYTE = 2'b10
   } lsu_type_e;

   typedef enum logic [2:0] {
      IDLE,
      GNT1,
      RVALID1,
      GNT2,
      RVALID2
   } lsu_fsm_e;

endpackage

// File: rtl/ibex_lsu_rdata_align.sv
// Load data aligner: shifts a two-word read window by the byte offset, then
// extracts and zero/sign-extends the byte, half or word.
module ibex_lsu_rdata_align
   import ibex_pkg::*;
(
   input  logic [63:0] window_i,
   input  logic [1:0]  offset_i,
   input  lsu_type_e   type_i,
   input  logic        sign_ext_i,
   output logic [31:0] rdata_o
);

   logic [31:0] shifted;

   assign shifted = 32'(window_i >> {offset_i, 3'b000});

   always_comb begin
      case (type_i)
         LSU_HALF: rdata_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
         LSU_BYTE: rdata_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
         default:  rdata_o = shifted;
      endcase
   end

endmodule

// File: rtl/ibex_lsu_resp_unit.sv
// Load/store bus sequencer: one request at a time, misaligned accesses split into
// two word transactions, load data aligned and extended for writeback.
module ibex_lsu_resp_unit
   import ibex_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   output logic        lsu_ready_o,
   input  logic        lsu_we_i,
   input  lsu_type_e   lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic        lsu_fp_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   input  logic [31:0] data_rdata_i,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_rf_we_o,
   output logic        lsu_fp_load_o,
   output logic        lsu_resp_valid_o,
   output logic        lsu_resp_err_o,
   output logic        lsu_busy_o
);

   lsu_fsm_e    state_q;
   lsu_type_e   type_q;
   logic        we_q, sign_q, fp_q;
   logic [31:0] addr_q, wdata_q, first_q;

   logic [1:0]  offset;
   logic        split, second;
   logic [3:0]  be_base, be;
   logic [31:0] word_addr, wdata_rot, align_rdata;
   logic [63:0] window;

   assign offset = addr_q[1:0];
   assign split  = ((type_q == LSU_WORD) && (offset != 2'b00)) ||
                   ((type_q == LSU_HALF) && (offset == 2'b11));
   assign second = (state_q == GNT2) || (state_q == RVALID2);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         type_q  <= LSU_WORD;
         we_q    <= 1'b0;
         sign_q  <= 1'b0;
         fp_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         first_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (lsu_req_i) begin
                  type_q  <= lsu_type_i;
                  we_q    <= lsu_we_i;
                  sign_q  <= lsu_sign_ext_i;
                  fp_q    <= lsu_fp_i;
                  addr_q  <= lsu_addr_i;
                  wdata_q <= lsu_wdata_i;
                  state_q <= GNT1;
               end
            end
            GNT1: if (data_gnt_i) state_q <= RVALID1;
            RVALID1: begin
               if (data_rvalid_i) begin
                  // An error on the first half aborts the whole access.
                  if (data_err_i || !split) begin
                     state_q <= IDLE;
                  end else begin
                     first_q <= data_rdata_i;
                     state_q <= GNT2;
                  end
               end
            end
            GNT2:    if (data_gnt_i) state_q <= RVALID2;
            RVALID2: if (data_rvalid_i) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (type_q)
         LSU_HALF: be_base = 4'b0011;
         LSU_BYTE: be_base = 4'b0001;
         default:  be_base = 4'b1111;
      endcase
      if (!split) begin
         be = be_base << offset;
      end else if (second) begin
         be = (type_q == LSU_HALF) ? 4'b0001 : (4'b1111 >> (3'd4 - {1'b0, offset}));
      end else begin
         be = (type_q == LSU_HALF) ? 4'b1000 : (4'b1111 << offset);
      end
   end

   assign word_addr = {addr_q[31:2], 2'b00} + (second ? 32'd4 : 32'd0);
   // Shift by 32 yields zero, so offset 0 degenerates to the identity.
   assign wdata_rot = (wdata_q << {offset, 3'b000}) |
                      (wdata_q >> (6'd32 - {1'b0, offset, 3'b000}));

   assign data_req_o   = (state_q == GNT1) || (state_q == GNT2);
   assign data_addr_o  = data_req_o ? word_addr : '0;
   assign data_we_o    = data_req_o & we_q;
   assign data_be_o    = data_req_o ? be : 4'b0000;
   assign data_wdata_o = data_req_o ? wdata_rot : '0;

   assign window = split ? {data_rdata_i, first_q} : {32'b0, data_rdata_i};

   ibex_lsu_rdata_align u_align (
      .window_i   (window),
      .offset_i   (offset),
      .type_i     (type_q),
      .sign_ext_i (sign_q),
      .rdata_o    (align_rdata)
   );

   assign lsu_resp_valid_o = data_rvalid_i &&
                             ((state_q == RVALID2) ||
                              ((state_q == RVALID1) && (data_err_i || !split)));
   assign lsu_resp_err_o   = lsu_resp_valid_o & data_err_i;
   assign lsu_rf_we_o      = lsu_resp_valid_o & ~we_q & ~data_err_i;
   assign lsu_rdata_o      = lsu_rf_we_o ? align_rdata : '0;
   assign lsu_fp_load_o    = fp_q;
   assign lsu_ready_o      = (state_q == IDLE);
   assign lsu_busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_lsu_resp_unit.sv
// Scoreboard bench for ibex_lsu_resp_unit: a simple bus slave with memory, expected
// bus accesses and responses queued at stimulus time and popped as the DUT produces them.
module tb_ibex_lsu_resp_unit;
   import ibex_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        lsu_req_i = 1'b0;
   logic        lsu_ready_o;
   logic        lsu_we_i = 1'b0;
   lsu_type_e   lsu_type_i = LSU_WORD;
   logic        lsu_sign_ext_i = 1'b0;
   logic        lsu_fp_i = 1'b0;
   logic [31:0] lsu_addr_i = '0;
   logic [31:0] lsu_wdata_i = '0;
   logic        data_req_o;
   logic        data_gnt_i = 1'b0;
   logic [31:0] data_addr_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i = 1'b0;
   logic        data_err_i = 1'b0;
   logic [31:0] data_rdata_i = '0;
   logic [31:0] lsu_rdata_o;
   logic        lsu_rf_we_o;
   logic        lsu_fp_load_o;
   logic        lsu_resp_valid_o;
   logic        lsu_resp_err_o;
   logic        lsu_busy_o;

   always #5 clk_i = ~clk_i;

   ibex_lsu_resp_unit dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .lsu_req_i        (lsu_req_i),
      .lsu_ready_o      (lsu_ready_o),
      .lsu_we_i         (lsu_we_i),
      .lsu_type_i       (lsu_type_i),
      .lsu_sign_ext_i   (lsu_sign_ext_i),
      .lsu_fp_i         (lsu_fp_i),
      .lsu_addr_i       (lsu_addr_i),
      .lsu_wdata_i      (lsu_wdata_i),
      .data_req_o       (data_req_o),
      .data_gnt_i       (data_gnt_i),
      .data_addr_o      (data_addr_o),
      .data_we_o        (data_we_o),
      .data_be_o        (data_be_o),
      .data_wdata_o     (data_wdata_o),
      .data_rvalid_i    (data_rvalid_i),
      .data_err_i       (data_err_i),
      .data_rdata_i     (data_rdata_i),
      .lsu_rdata_o      (lsu_rdata_o),
      .lsu_rf_we_o      (lsu_rf_we_o),
      .lsu_fp_load_o    (lsu_fp_load_o),
      .lsu_resp_valid_o (lsu_resp_valid_o),
      .lsu_resp_err_o   (lsu_resp_err_o),
      .lsu_busy_o       (lsu_busy_o)
   );

   typedef struct packed {
      logic        err;
      logic        rf_we;
      logic        fp;
      logic [31:0] rdata;
   } resp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
   } bus_t;

   resp_t       resp_q[$];
   bus_t        bus_q[$];
   logic [31:0] mem [logic [31:0]];

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   int          resp_cnt = 0;
   int          resp_cyc = 0;
   int          gnt_cnt = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic        gnt_en = 1'b1;
   logic        stray = 1'b0;
   logic [31:0] err_addr = 32'hFFFF_FFFC;

   // One clock: bus slave drives after the edge, outputs sampled on the falling edge.
   task automatic cycle();
      bus_t  b;
      resp_t r;
      @(posedge clk_i);
      cyc++;
      #1;
      data_rvalid_i = pend | stray;
      data_rdata_i  = pend ? mem[pend_addr] : 32'hA5A5_A5A5;
      data_err_i    = pend && (pend_addr == err_addr);
      pend  = 1'b0;
      stray = 1'b0;
      data_gnt_i = data_req_o & gnt_en;
      if (data_gnt_i) begin
         pend      = 1'b1;
         pend_addr = data_addr_o;
      end
      @(negedge clk_i);
      if (data_gnt_i) begin
         gnt_cnt++;
         checks++;
         if (bus_q.size() == 0) begin
            errors++;
            $display("FAIL bus_access: unexpected access addr=%h be=%b", data_addr_o, data_be_o);
         end else begin
            b = bus_q.pop_front();
            if (data_addr_o !== b.addr || data_be_o !== b.be || data_we_o !== b.we ||
                (b.we && data_wdata_o !== b.wdata)) begin
               errors++;
               $display("FAIL bus_access: got addr=%h be=%b we=%b wdata=%h want addr=%h be=%b we=%b wdata=%h",
                        data_addr_o, data_be_o, data_we_o, data_wdata_o, b.addr, b.be, b.we, b.wdata);
            end
         end
      end
      if (lsu_resp_valid_o) begin
         resp_cnt++;
         resp_cyc = cyc;
         checks++;
         if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL response: unexpected response err=%b rf_we=%b", lsu_resp_err_o, lsu_rf_we_o);
         end else begin
            r = resp_q.pop_front();
            if (lsu_resp_err_o !== r.err || lsu_rf_we_o !== r.rf_we || lsu_fp_load_o !== r.fp ||
                (r.rf_we && lsu_rdata_o !== r.rdata)) begin
               errors++;
               $display("FAIL response: got err=%b rf_we=%b fp=%b rdata=%h want err=%b rf_we=%b fp=%b rdata=%h",
                        lsu_resp_err_o, lsu_rf_we_o, lsu_fp_load_o, lsu_rdata_o,
                        r.err, r.rf_we, r.fp, r.rdata);
            end
         end
      end
   endtask

   task automatic issue(input logic we, input lsu_type_e t, input logic sign, input logic fp,
                        input logic [31:0] addr, input logic [31:0] wdata, output int n);
      lsu_req_i = 1'b1;
      lsu_we_i = we;
      lsu_type_i = t;
      lsu_sign_ext_i = sign;
      lsu_fp_i = fp;
      lsu_addr_i = addr;
      lsu_wdata_i = wdata;
      n = cyc;
      cycle();
      lsu_req_i = 1'b0;
   endtask

   task automatic wait_resp(input string name);
      int start = resp_cnt;
      int k = 0;
      while (resp_cnt == start && k < 20) begin
         cycle();
         k++;
      end
      checks++;
      if (resp_cnt == start) begin
         errors++;
         $display("FAIL %s_timeout: no response after %0d cycles, wanted one", name, k);
      end
      cycle();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      cycle();
      cycle();
      rst_i = 1'b0;
      checks++;
      if (lsu_ready_o !== 1'b1 || lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b busy=%b req=%b want 1 0 0",
                  lsu_ready_o, lsu_busy_o, data_req_o);
      end
      checks++;
      if (data_be_o !== 4'b0 || data_addr_o !== 32'b0 || data_we_o !== 1'b0 ||
          data_wdata_o !== 32'b0) begin
         errors++;
         $display("FAIL reset_bus: be=%b addr=%h we=%b wdata=%h want all zero",
                  data_be_o, data_addr_o, data_we_o, data_wdata_o);
      end
      checks++;
      if (lsu_resp_valid_o !== 1'b0 || lsu_resp_err_o !== 1'b0 || lsu_rf_we_o !== 1'b0 ||
          lsu_fp_load_o !== 1'b0 || lsu_rdata_o !== 32'b0) begin
         errors++;
         $display("FAIL reset_resp: valid=%b err=%b rf_we=%b fp=%b rdata=%h want all zero",
                  lsu_resp_valid_o, lsu_resp_err_o, lsu_rf_we_o, lsu_fp_load_o, lsu_rdata_o);
      end
   endtask

   task automatic test_aligned_lw();
      int n;
      int g0 = gnt_cnt;
      bus_q.push_back('{addr: 32'h1000, be: 4'b1111, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'hDEAD_BEEF});
      issue(1'b0, LSU_WORD, 1'b0, 1'b0, 32'h1000, '0, n);
      wait_resp("aligned_lw");
      checks++;
      if (resp_cyc !== n + 2 || gnt_cnt - g0 !== 1) begin
         errors++;
         $display("FAIL aligned_lw_timing: result cycle=%0d accesses=%0d want %0d and 1",
                  resp_cyc - n, gnt_cnt - g0, 2);
      end
   endtask

   task automatic test_misaligned_lw();
      int n;
      bus_q.push_back('{addr: 32'h1000, be: 4'b1100, we: 1'b0, wdata: '0});
      bus_q.push_back('{addr: 32'h1004, be: 4'b0011, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'h6655_4433});
      issue(1'b0, LSU_WORD, 1'b0, 1'b0, 32'h1002, '0, n);
      wait_resp("misaligned_lw");
      checks++;
      if (resp_cyc !== n + 4) begin
         errors++;
         $display("FAIL misaligned_lw_timing: result at N+%0d want N+4", resp_cyc - n);
      end
   endtask

   task automatic test_byte_half();
      int n;
      bus_q.push_back('{addr: 32'h2000, be: 4'b1000, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'hFFFF_FF80});
      issue(1'b0, LSU_BYTE, 1'b1, 1'b0, 32'h2003, '0, n);
      wait_resp("lb");
      bus_q.push_back('{addr: 32'h2000, be: 4'b1000, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'h0000_0080});
      issue(1'b0, LSU_BYTE, 1'b0, 1'b0, 32'h2003, '0, n);
      wait_resp("lbu");
      bus_q.push_back('{addr: 32'h2000, be: 4'b1100, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'hFFFF_8012});
      issue(1'b0, LSU_HALF, 1'b1, 1'b0, 32'h2002, '0, n);
      wait_resp("lh");
      // Half at offset 3 straddles the word boundary.
      bus_q.push_back('{addr: 32'h2000, be: 4'b1000, we: 1'b0, wdata: '0});
      bus_q.push_back('{addr: 32'h2004, be: 4'b0001, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b0, rdata: 32'hFFFF_AB80});
      issue(1'b0, LSU_HALF, 1'b1, 1'b0, 32'h2003, '0, n);
      wait_resp("lh_split");
   endtask

   task automatic test_store();
      int n;
      bus_q.push_back('{addr: 32'h3000, be: 4'b1110, we: 1'b1, wdata: 32'h2233_4411});
      bus_q.push_back('{addr: 32'h3004, be: 4'b0001, we: 1'b1, wdata: 32'h2233_4411});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b0, fp: 1'b0, rdata: '0});
      issue(1'b1, LSU_WORD, 1'b0, 1'b0, 32'h3001, 32'h1122_3344, n);
      wait_resp("sw_split");
      bus_q.push_back('{addr: 32'h3000, be: 4'b0100, we: 1'b1, wdata: 32'h00AB_0000});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b0, fp: 1'b0, rdata: '0});
      issue(1'b1, LSU_BYTE, 1'b0, 1'b0, 32'h3002, 32'h0000_00AB, n);
      wait_resp("sb");
   endtask

   task automatic test_error();
      int n;
      int g0 = gnt_cnt;
      err_addr = 32'h1000;
      bus_q.push_back('{addr: 32'h1000, be: 4'b1000, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b1, rf_we: 1'b0, fp: 1'b0, rdata: '0});
      issue(1'b0, LSU_WORD, 1'b0, 1'b0, 32'h1003, '0, n);
      wait_resp("split_err");
      cycle();
      cycle();
      checks++;
      if (gnt_cnt - g0 !== 1 || data_req_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL split_err_abort: accesses=%0d req=%b ready=%b want 1 0 1",
                  gnt_cnt - g0, data_req_o, lsu_ready_o);
      end
      err_addr = 32'hFFFF_FFFC;
   endtask

   task automatic test_fp_load();
      int n;
      bus_q.push_back('{addr: 32'h4000, be: 4'b1111, we: 1'b0, wdata: '0});
      resp_q.push_back('{err: 1'b0, rf_we: 1'b1, fp: 1'b1, rdata: 32'h3F80_0000});
      issue(1'b0, LSU_WORD, 1'b0, 1'b1, 32'h4000, '0, n);
      wait_resp("flw");
   endtask

   task automatic test_reset_mid();
      int n;
      int r0;
      bus_q.push_back('{addr: 32'h1000, be: 4'b1100, we: 1'b0, wdata: '0});
      issue(1'b0, LSU_WORD, 1'b0, 1'b0, 32'h1002, '0, n);
      gnt_en = 1'b0;
      cycle();
      cycle();
      checks++;
      if (data_req_o !== 1'b1 || data_addr_o !== 32'h1004 || lsu_busy_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_gnt2: req=%b addr=%h busy=%b want 1 00001004 1",
                  data_req_o, data_addr_o, lsu_busy_o);
      end
      rst_i = 1'b1;
      cycle();
      rst_i = 1'b0;
      checks++;
      if (data_req_o !== 1'b0 || lsu_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_idle: req=%b ready=%b want 0 1", data_req_o, lsu_ready_o);
      end
      r0 = resp_cnt;
      stray = 1'b1;
      cycle();
      cycle();
      checks++;
      if (resp_cnt !== r0) begin
         errors++;
         $display("FAIL stray_rvalid: responses=%0d want 0", resp_cnt - r0);
      end
      gnt_en = 1'b1;
   endtask

   initial begin
      mem[32'h1000] = 32'h4433_2211;
      mem[32'h1004] = 32'h8877_6655;
      mem[32'h2000] = 32'h8012_3456;
      mem[32'h2004] = 32'h0000_00AB;
      mem[32'h3000] = 32'h0;
      mem[32'h3004] = 32'h0;
      mem[32'h4000] = 32'h3F80_0000;

      test_reset();
      mem[32'h1000] = 32'hDEAD_BEEF;
      test_aligned_lw();
      mem[32'h1000] = 32'h4433_2211;
      test_misaligned_lw();
      test_byte_half();
      test_store();
      test_error();
      test_fp_load();
      test_reset_mid();

      checks++;
      if (resp_q.size() != 0 || bus_q.size() != 0) begin
         errors++;
         $display("FAIL leftovers: responses=%0d accesses=%0d still expected, want 0 0",
                  resp_q.size(), bus_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ibex_lsu_resp_unit.md
# ibex_lsu_resp_unit

Load/store data-bus sequencer between the ID/EX stage and the writeback stage. It accepts one memory request at a time and splits misaligned accesses into two word transactions. It aligns and sign-extends load data, then presents the result together with a response valid/error strobe and an FP-load flag. The writeback stage uses these to route load data into the integer or FP register file.

## Interface
Parameters: none.

- clk_i  in  1  clock
- rst_i  in  1  reset; **synchronous, active-high**, single clock domain
- lsu_req_i  in  1  request from ID/EX; accepted when lsu_ready_o=1
- lsu_ready_o  out  1  unit idle, can accept a request
- lsu_we_i  in  1  1=store, 0=load
- lsu_type_i  in  2  ibex_pkg::lsu_type_e: WORD/HALF/BYTE
- lsu_sign_ext_i  in  1  sign-extend half/byte load
- lsu_fp_i  in  1  load targets FP register file
- lsu_addr_i  in  32  byte address
- lsu_wdata_i  in  32  store data, LSB-aligned
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_addr_o  out  32  word-aligned address ([1:0]=0)
- data_we_o  out  1  bus write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  rotated store data
- data_rvalid_i  in  1  bus response valid
- data_err_i  in  1  bus error, qualified by rvalid
- data_rdata_i  in  32  bus read data
- lsu_rdata_o  out  32  aligned, extended load data
- lsu_rf_we_o  out  1  write lsu_rdata_o to RF (load, no error)
- lsu_fp_load_o  out  1  captured lsu_fp_i of current op
- lsu_resp_valid_o  out  1  operation complete (load or store)
- lsu_resp_err_o  out  1  operation complete with bus error
- lsu_busy_o  out  1  state != IDLE

## Operation
- FSM states: IDLE, GNT1, RVALID1, GNT2, RVALID2.
- IDLE: lsu_ready_o=1. On lsu_req_i, capture we/type/sign/fp/addr/wdata and go to GNT1.
- A request is split when it is a WORD with addr[1:0]!=0, or a HALF with addr[1:0]=3.
- GNT1: data_req_o=1, addr={addr_q[31:2],2'b00}. On data_gnt_i go to RVALID1.
- RVALID1: on data_rvalid_i:
  - error → complete with err, skip the second access, go to IDLE.
  - split → store rdata in first_q, go to GNT2.
  - otherwise → complete, go to IDLE.
- GNT2: data_req_o=1, addr=word address+4, wrapping mod 2^32. On grant go to RVALID2.
- RVALID2: on data_rvalid_i, complete and go to IDLE.
- data_rvalid_i in IDLE/GNT1/GNT2 is ignored.
- Byte enables, with o=addr_q[1:0]:
  - unsplit: base mask (WORD 1111, HALF 0011, BYTE 0001) shifted left by o.
  - split first: WORD 1111<<o, HALF 1000.
  - split second: WORD 1111>>(4-o), HALF 0001.
- data_wdata_o = lsu_wdata rotated left by 8*o, in both halves.
- Load alignment:
  - unsplit: rdata >> 8*o.
  - split: {data_rdata_i, first_q} >> 8*o, low 32 bits.
  - Then extract byte/half and zero- or sign-extend (sign from bit 7/15 when lsu_sign_ext_i).
- Completion cycle:
  - lsu_resp_valid_o=1.
  - lsu_resp_err_o=data_err_i.
  - lsu_rf_we_o = ~we_q & ~data_err_i.
  - lsu_fp_load_o = fp_q.
- lsu_resp_valid_o/err/rf_we are combinational from data_rvalid_i in the RVALID state.
- Reset:
  - state=IDLE; captured registers and first_q cleared.
  - All outputs 0 except lsu_ready_o=1.
- Reset mid-operation: IDLE next cycle, data_req_o deasserts, no response is issued, late bus rvalid is ignored.

## Timing
- Request accepted at cycle N → data_req_o=1 at N+1.
- Grant at cycle G → RVALID state at G+1. Earliest rvalid is at G+1.
- Unsplit load with immediate grant and rvalid: result at N+2.
- Split load: result at N+4 at minimum.
- data_req_o and the address/be/wdata outputs stay stable until granted.
- lsu_ready_o returns to 1 the cycle after completion. There is no back-to-back acceptance in the completion cycle.
- lsu_rdata_o is valid only when lsu_rf_we_o=1. Otherwise it is don't-care but driven deterministically.

## Structure
- ibex_pkg holds:
  - lsu_type_e (LSU_WORD=2'b00, LSU_HALF=2'b01, LSU_BYTE=2'b10)
  - lsu_fsm_e (the five states)
- Sub-module ibex_lsu_rdata_align: purely combinational. Inputs: 64-bit window, offset, type, sign. Output: 32-bit result.
- FSM, capture registers, byte-enable and wdata logic live in the top module.

## Test plan
- Aligned LW at 0x1000, mem word 0xDEADBEEF, grant/rvalid immediate → one bus access, be=1111, lsu_rdata_o=0xDEADBEEF, lsu_rf_we_o=1 at N+2.
- Misaligned LW at 0x1002; words 0x1000=0x4433_2211 and 0x1004=0x8877_6655 → accesses at 0x1000 be=1100 then 0x1004 be=0011; lsu_rdata_o=0x6655_4433.
- LB signed at 0x2003, byte 0x80 → be=1000, lsu_rdata_o=0xFFFF_FF80. LBU same → 0x0000_0080.
- SW 0x11223344 at 0x3001 → first access be=1110, wdata=0x22334411; second at 0x3004 be=0001; resp_valid=1, rf_we=0.
- Split LW at 0x1003, first rvalid with err=1 → no second req, resp_valid=1, err=1, rf_we=0, back in IDLE.
- FLW at 0x4000 with lsu_fp_i=1 → lsu_fp_load_o=1 with resp_valid. Then rst_i asserted in GNT2 of a split load → next cycle data_req_o=0, lsu_ready_o=1, and a following stray rvalid yields no response.
